// File: rtl/fifo_read_executor.sv
// fifo_read_executor
//   Consumer side of the weighted round-robin arbiter grant interface. Each
//   accepted grant pops one output FIFO. The synchronous-read word is captured
//   one cycle later and presented to the egress port. A one-entry skid buffer
//   absorbs the word that is already in flight when the egress stalls.
//
// Optional feature (macro READ_EXEC_STATS_EN):
//   Adds served_count, a 16-bit wrapping pop counter per queue.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   enb             block enable (gates grant acceptance only)
//   selector        granted queue index
//   selector_enb    grant strobe
//   buf_empty       per-queue FIFO empty flags
//   fifo_data       concatenated FIFO read ports, queue i at [i*DATA_BITS +: DATA_BITS]
//   downstream_full egress cannot take a word this cycle
//   pop             one-hot FIFO read strobe (combinational)
//   data_out        word to egress
//   valid_out       data_out valid
//   grant_err       one-cycle pulse for a rejected grant
//   state_dbg       output-stage FSM state (0 EMPTY, 1 FULL, 2 SKID)
//   served_count    per-queue pop counters (READ_EXEC_STATS_EN only)
//
// Handshake: a word is transferred to egress in every cycle where
// valid_out=1 and downstream_full=0. While valid_out=1 and downstream_full=1,
// data_out holds its value.
module fifo_read_executor #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  localparam int SEL_W         = $clog2(QUEUE_QUANTITY)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [SEL_W-1:0]                    selector,
  input  logic                                selector_enb,
  input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data,
  input  logic                                downstream_full,
  output logic [QUEUE_QUANTITY-1:0]           pop,
  output logic [DATA_BITS-1:0]                data_out,
  output logic                                valid_out,
  output logic                                grant_err,
  output logic [1:0]                          state_dbg
`ifdef READ_EXEC_STATS_EN
  ,
  output logic [QUEUE_QUANTITY*16-1:0]        served_count
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   in_flight_q;
  logic [SEL_W-1:0]       flight_idx_q;
  logic [DATA_BITS-1:0]   skid_q;
  logic [DATA_BITS-1:0]   rd_word;

  logic sel_in_range, sel_empty, grant_req;
  logic accept, reject, capture, consume, skid_valid;
  logic load_out, load_out_from_skid, load_skid;

  // Grant qualification. selector can exceed the queue count when
  // QUEUE_QUANTITY is not a power of two; such a grant reads as empty.
  always_comb begin
    sel_in_range = (32'(selector) < QUEUE_QUANTITY);
    sel_empty    = sel_in_range ? buf_empty[selector] : 1'b1;
    grant_req    = enb & selector_enb;
    // A grant is only taken when the word it produces is guaranteed a slot:
    // the skid must be free and the egress must be draining this cycle.
    accept       = rst & grant_req & ~sel_empty & ~skid_valid & ~downstream_full;
    reject       = grant_req & sel_empty;
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      pop[i] = accept && (32'(selector) == i);
    end
  end

  // The word of the grant accepted last cycle is on its FIFO slice now.
  assign rd_word    = fifo_data[flight_idx_q*DATA_BITS +: DATA_BITS];
  assign capture    = in_flight_q;
  assign valid_out  = (state_q != ST_EMPTY);
  assign skid_valid = (state_q == ST_SKID);
  assign consume    = valid_out & ~downstream_full;
  assign state_dbg  = state_q;

  // Output-stage FSM. Capture in SKID cannot happen: accept is blocked
  // whenever a capture could land while the output register is stalled.
  always_comb begin
    state_d            = state_q;
    load_out           = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (capture) begin
          state_d  = ST_FULL;
          load_out = 1'b1;
        end
      end
      ST_FULL: begin
        if (consume && capture) begin
          load_out = 1'b1;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end else if (capture) begin
          state_d   = ST_SKID;
          load_skid = 1'b1;
        end
      end
      ST_SKID: begin
        if (consume) begin
          state_d            = ST_FULL;
          load_out_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_EMPTY;
      in_flight_q  <= 1'b0;
      flight_idx_q <= '0;
      grant_err    <= 1'b0;
      data_out     <= '0;
      skid_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= accept;
      grant_err   <= reject;
      if (accept) flight_idx_q <= selector;
      if (load_out) begin
        data_out <= rd_word;
      end else if (load_out_from_skid) begin
        data_out <= skid_q;
      end
      if (load_skid) skid_q <= rd_word;
    end
  end

`ifdef READ_EXEC_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      served_count <= '0;
    end else begin
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
        if (pop[i]) served_count[i*16 +: 16] <= served_count[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_executor.sv
// tb_fifo_read_executor
//   Bench for fifo_read_executor. Main instance uses 4 queues of 8-bit words
//   behind a bench FIFO model with synchronous read; a second instance with
//   3 queues covers the out-of-range selector. Expected words are queued when
//   grants are driven and checked as the egress consumes them.
module tb_fifo_read_executor;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic [1:0]  selector;
  logic        selector_enb;
  logic [3:0]  buf_empty;
  logic [31:0] fifo_data;
  logic        downstream_full;
  logic [3:0]  pop;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        grant_err;
  logic [1:0]  state_dbg;

  logic [1:0]  sel3;
  logic        sel_enb3;
  logic [2:0]  buf_empty3;
  logic [23:0] fifo_data3;
  logic        full3;
  logic [2:0]  pop3;
  logic [7:0]  data_out3;
  logic        valid_out3;
  logic        grant_err3;
  logic [1:0]  state_dbg3;
`ifdef READ_EXEC_STATS_EN
  logic [63:0] served_count;
  logic [47:0] served_count3;
`endif

  fifo_read_executor #(.QUEUE_QUANTITY(4), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .enb(enb), .selector(selector),
    .selector_enb(selector_enb), .buf_empty(buf_empty), .fifo_data(fifo_data),
    .downstream_full(downstream_full), .pop(pop), .data_out(data_out),
    .valid_out(valid_out), .grant_err(grant_err), .state_dbg(state_dbg)
`ifdef READ_EXEC_STATS_EN
    , .served_count(served_count)
`endif
  );

  fifo_read_executor #(.QUEUE_QUANTITY(3), .DATA_BITS(8)) dut3 (
    .clk(clk), .rst(rst), .enb(enb), .selector(sel3),
    .selector_enb(sel_enb3), .buf_empty(buf_empty3), .fifo_data(fifo_data3),
    .downstream_full(full3), .pop(pop3), .data_out(data_out3),
    .valid_out(valid_out3), .grant_err(grant_err3), .state_dbg(state_dbg3)
`ifdef READ_EXEC_STATS_EN
    , .served_count(served_count3)
`endif
  );

  // clock
  always #5 clk = ~clk;

  // FIFO model and scoreboard state
  logic [7:0] fifo_mem [4][8];
  int         fifo_cnt [4];
  int         rd_ptr   [4];
  int         wr_ptr   [4];
  logic [3:0] model_hit;
  logic       endless;
  logic       sb_on;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;
  int         n_cmp;
  int         n_err;

  always_comb begin
    buf_empty = '0;
    for (int q = 0; q < 4; q++) buf_empty[q] = (fifo_cnt[q] == 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int q, input logic [7:0] w);
    fifo_mem[q][wr_ptr[q]] = w;
    wr_ptr[q]   = (wr_ptr[q] + 1) % 8;
    fifo_cnt[q] = fifo_cnt[q] + 1;
  endtask

  // Synchronous-read FIFO: a pop in cycle N puts the word on the slice at the
  // edge ending N. The count update is deferred past the edge so the DUT
  // samples the pre-pop empty flags.
  task automatic fifo_model();
    forever begin
      @(posedge clk);
      model_hit = '0;
      for (int q = 0; q < 4; q++) begin
        if (pop[q] && fifo_cnt[q] > 0) begin
          fifo_data[q*8 +: 8] <= fifo_mem[q][rd_ptr[q]];
          model_hit[q] = 1'b1;
        end
      end
      #1;
      for (int q = 0; q < 4; q++) begin
        if (model_hit[q] && !endless) begin
          rd_ptr[q]   = (rd_ptr[q] + 1) % 8;
          fifo_cnt[q] = fifo_cnt[q] - 1;
        end
      end
    end
  endtask

  task automatic sb_monitor();
    forever begin
      @(negedge clk);
      if (sb_on && rst && valid_out && !downstream_full) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_extra_word: got %h, expected queue empty", data_out);
        end else begin
          exp_w = exp_q.pop_front();
          if (data_out !== exp_w) begin
            n_err++;
            $display("FAIL sb_order: got %h want %h", data_out, exp_w);
          end
        end
      end
      // Nothing may be popped while the skid is occupied.
      if (state_dbg == 2'd2) begin
        n_cmp++;
        if (pop !== 4'b0000) begin
          n_err++;
          $display("FAIL skid_no_pop: pop %b want 0000", pop);
        end
      end
    end
  endtask

  task automatic test_reset();
    enb = 1'b1; selector = 2'd0; selector_enb = 1'b1;
    repeat (2) step();
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", valid_out); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", data_out); end
    n_cmp++; if (pop !== 4'b0000) begin n_err++; $display("FAIL rst_pop: got %b want 0000", pop); end
    n_cmp++; if (grant_err !== 1'b0) begin n_err++; $display("FAIL rst_gerr: got %b want 0", grant_err); end
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
    n_cmp++; if (state_dbg3 !== 2'd0) begin n_err++; $display("FAIL rst_state3: got %0d want 0", state_dbg3); end
    selector_enb = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    push_word(2, 8'hA5);
    enb = 1'b1; selector = 2'd2; selector_enb = 1'b1;
    exp_q.push_back(8'hA5);
    #1;
    n_cmp++; if (pop !== 4'b0100) begin n_err++; $display("FAIL single_pop: got %b want 0100", pop); end
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL single_valid_n: got %b want 0", valid_out); end
    step();
    selector_enb = 1'b0;
    #1;
    n_cmp++; if (pop !== 4'b0000) begin n_err++; $display("FAIL single_pop_n1: got %b want 0000", pop); end
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL single_valid_n1: got %b want 0", valid_out); end
    step();
    n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL single_valid_n2: got %b want 1", valid_out); end
    n_cmp++; if (data_out !== 8'hA5) begin n_err++; $display("FAIL single_data_n2: got %h want a5", data_out); end
    step();
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL single_valid_n3: got %b want 0", valid_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    int         sels  [4];
    logic [3:0] exp_pop;
    logic       exp_valid;
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    sels  = '{0, 1, 3, 0};
    for (int i = 0; i < 4; i++) push_word(sels[i], words[i]);
    for (int c = 0; c < 7; c++) begin
      exp_pop = 4'b0000;
      if (c < 4) begin
        selector = 2'(sels[c]); selector_enb = 1'b1;
        exp_q.push_back(words[c]);
        exp_pop = 4'b0001 << sels[c];
      end else begin
        selector_enb = 1'b0;
      end
      #1;
      exp_valid = (c >= 2 && c < 6);
      n_cmp++; if (pop !== exp_pop) begin n_err++; $display("FAIL b2b_pop c%0d: got %b want %b", c, pop, exp_pop); end
      n_cmp++; if (valid_out !== exp_valid) begin n_err++; $display("FAIL b2b_valid c%0d: got %b want %b", c, valid_out, exp_valid); end
      if (exp_valid) begin
        n_cmp++; if (data_out !== words[c-2]) begin n_err++; $display("FAIL b2b_data c%0d: got %h want %h", c, data_out, words[c-2]); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    push_word(1, 8'h55); push_word(2, 8'h66); push_word(3, 8'h77);
    downstream_full = 1'b0;
    selector = 2'd1; selector_enb = 1'b1; exp_q.push_back(8'h55);
    #1;
    n_cmp++; if (pop !== 4'b0010) begin n_err++; $display("FAIL bp_pop0: got %b want 0010", pop); end
    step();
    selector = 2'd2; exp_q.push_back(8'h66);
    #1;
    n_cmp++; if (pop !== 4'b0100) begin n_err++; $display("FAIL bp_pop1: got %b want 0100", pop); end
    step();
    downstream_full = 1'b1; selector = 2'd3;
    #1;
    n_cmp++; if (pop !== 4'b0000) begin n_err++; $display("FAIL bp_pop2: got %b want 0000", pop); end
    n_cmp++; if (data_out !== 8'h55) begin n_err++; $display("FAIL bp_data2: got %h want 55", data_out); end
    step();
    for (int c = 3; c < 6; c++) begin
      #1;
      n_cmp++; if (pop !== 4'b0000) begin n_err++; $display("FAIL bp_hold_pop c%0d: got %b want 0000", c, pop); end
      n_cmp++; if (valid_out !== 1'b1 || data_out !== 8'h55) begin n_err++; $display("FAIL bp_hold_data c%0d: got %b/%h want 1/55", c, valid_out, data_out); end
      n_cmp++; if (state_dbg !== 2'd2) begin n_err++; $display("FAIL bp_state c%0d: got %0d want 2", c, state_dbg); end
      n_cmp++; if (grant_err !== 1'b0) begin n_err++; $display("FAIL bp_gerr c%0d: got %b want 0", c, grant_err); end
      step();
    end
    downstream_full = 1'b0;
    #1;
    n_cmp++; if (pop !== 4'b0000) begin n_err++; $display("FAIL bp_rel_pop: got %b want 0000", pop); end
    step();
    exp_q.push_back(8'h77);
    #1;
    n_cmp++; if (pop !== 4'b1000) begin n_err++; $display("FAIL bp_regrant_pop: got %b want 1000", pop); end
    n_cmp++; if (data_out !== 8'h66) begin n_err++; $display("FAIL bp_skid_out: got %h want 66", data_out); end
    step();
    selector_enb = 1'b0;
    #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL bp_bubble: got %b want 0", valid_out); end
    step();
    n_cmp++; if (valid_out !== 1'b1 || data_out !== 8'h77) begin n_err++; $display("FAIL bp_last: got %b/%h want 1/77", valid_out, data_out); end
    step();
  endtask

  task automatic test_grant_err();
    push_word(0, 8'h01); push_word(2, 8'h02); push_word(3, 8'h03);
    selector = 2'd1; selector_enb = 1'b1;
    #1;
    n_cmp++; if (pop !== 4'b0000) begin n_err++; $display("FAIL empty_pop: got %b want 0000", pop); end
    n_cmp++; if (grant_err !== 1'b0) begin n_err++; $display("FAIL empty_gerr_n: got %b want 0", grant_err); end
    step();
    selector_enb = 1'b0;
    n_cmp++; if (grant_err !== 1'b1) begin n_err++; $display("FAIL empty_gerr_n1: got %b want 1", grant_err); end
    step();
    n_cmp++; if (grant_err !== 1'b0) begin n_err++; $display("FAIL empty_gerr_n2: got %b want 0", grant_err); end
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL empty_valid: got %b want 0", valid_out); end
    // out-of-range index on the 3-queue instance
    sel3 = 2'd3; sel_enb3 = 1'b1;
    #1;
    n_cmp++; if (pop3 !== 3'b000) begin n_err++; $display("FAIL oor_pop: got %b want 000", pop3); end
    step();
    sel_enb3 = 1'b0;
    n_cmp++; if (grant_err3 !== 1'b1) begin n_err++; $display("FAIL oor_gerr_n1: got %b want 1", grant_err3); end
    step();
    n_cmp++; if (grant_err3 !== 1'b0) begin n_err++; $display("FAIL oor_gerr_n2: got %b want 0", grant_err3); end
    sel3 = 2'd2; sel_enb3 = 1'b1;
    #1;
    n_cmp++; if (pop3 !== 3'b100) begin n_err++; $display("FAIL q3_pop: got %b want 100", pop3); end
    step();
    sel_enb3 = 1'b0;
    step();
    n_cmp++; if (valid_out3 !== 1'b1 || data_out3 !== 8'hC3) begin n_err++; $display("FAIL q3_data: got %b/%h want 1/c3", valid_out3, data_out3); end
    step();
    // disabled block ignores a valid grant without error
    enb = 1'b0; selector = 2'd0; selector_enb = 1'b1;
    #1;
    n_cmp++; if (pop !== 4'b0000) begin n_err++; $display("FAIL enb0_pop: got %b want 0000", pop); end
    step();
    n_cmp++; if (grant_err !== 1'b0) begin n_err++; $display("FAIL enb0_gerr: got %b want 0", grant_err); end
    selector_enb = 1'b0; enb = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    downstream_full = 1'b0;
    selector = 2'd2; selector_enb = 1'b1;
    step();
    selector = 2'd3;
    step();
    downstream_full = 1'b1; selector_enb = 1'b0;
    step();
    #1;
    n_cmp++; if (state_dbg !== 2'd2 || data_out !== 8'h02) begin n_err++; $display("FAIL rm_pre: got %0d/%h want 2/02", state_dbg, data_out); end
    selector = 2'd0; selector_enb = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b want 0", valid_out); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rm_data: got %h want 00", data_out); end
    n_cmp++; if (pop !== 4'b0000) begin n_err++; $display("FAIL rm_pop: got %b want 0000", pop); end
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rm_state: got %0d want 0", state_dbg); end
    step();
    step();
    rst = 1'b1; selector_enb = 1'b0; downstream_full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (valid_out !== 1'b0 || data_out !== 8'h00) begin n_err++; $display("FAIL rm_after c%0d: got %b/%h want 0/00", c, valid_out, data_out); end
    end
  endtask

`ifdef READ_EXEC_STATS_EN
  task automatic test_stats();
    push_word(0, 8'h5A);
    endless = 1'b1; sb_on = 1'b0; downstream_full = 1'b0;
    selector = 2'd0; selector_enb = 1'b1;
    repeat (65537) step();
    selector_enb = 1'b0;
    repeat (4) step();
    n_cmp++; if (served_count[15:0] !== 16'd1) begin n_err++; $display("FAIL stats_q0: got %0d want 1", served_count[15:0]); end
    n_cmp++; if (served_count[63:16] !== 48'd0) begin n_err++; $display("FAIL stats_others: got %h want 0", served_count[63:16]); end
    n_cmp++; if (served_count3 !== 48'd0) begin n_err++; $display("FAIL stats_dut3: got %h want 0", served_count3); end
    endless = 1'b0; sb_on = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b0; enb = 1'b0; selector = '0; selector_enb = 1'b0;
    downstream_full = 1'b0; fifo_data = '0;
    sel3 = '0; sel_enb3 = 1'b0; buf_empty3 = 3'b000; fifo_data3 = 24'hC3B2A1; full3 = 1'b0;
    endless = 1'b0; sb_on = 1'b1; n_cmp = 0; n_err = 0; model_hit = '0;
    for (int q = 0; q < 4; q++) begin
      fifo_cnt[q] = 0; rd_ptr[q] = 0; wr_ptr[q] = 0;
      for (int k = 0; k < 8; k++) fifo_mem[q][k] = '0;
    end
    fork
      fifo_model();
      sb_monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_grant_err();
    test_reset_mid();
`ifdef READ_EXEC_STATS_EN
    test_stats();
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d words never emerged, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_read_executor.md
Name: fifo_read_executor

Overview:
- Consumer side of the weighted round-robin arbiter's grant interface.
- Takes each selector/selector_enb grant and pops the chosen output FIFO. Captures the word the FIFO returns and presents it downstream under a valid/full backpressure handshake.
- Sits between the queue bank and the egress port. Has a one-entry skid buffer, so grants can be accepted back-to-back without losing in-flight data.

Parameters:
QUEUE_QUANTITY, 4, number of queues (>=2, need not be a power of two)
DATA_BITS, 8, width of one queue word

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset
enb  input  1  block enable; when 0 no new grant is accepted, in-flight data still drains
selector  input  $clog2(QUEUE_QUANTITY)  granted queue index from arbiter
selector_enb  input  1  grant strobe, one grant per cycle
buf_empty  input  QUEUE_QUANTITY  per-queue FIFO empty flags
fifo_data  input  QUEUE_QUANTITY*DATA_BITS  concatenated FIFO read ports; queue i at bits [i*DATA_BITS +: DATA_BITS]
downstream_full  input  1  egress cannot take a word this cycle
pop  output  QUEUE_QUANTITY  one-hot FIFO read strobe
data_out  output  DATA_BITS  word to egress
valid_out  output  1  data_out valid
grant_err  output  1  one-cycle pulse: grant rejected (empty queue or index out of range)

Behaviour:
- Reset (rst=0, asynchronous): pop=0, data_out=0, valid_out=0, grant_err=0, skid empty, in-flight flag cleared. A grant popped before reset has its word discarded; no recovery is attempted.
- Accept condition in cycle N: enb & selector_enb & selector<QUEUE_QUANTITY & !buf_empty[selector] & !skid_valid & !downstream_full.
- pop is combinational, asserted in cycle N: pop[selector]=1, all other bits 0. No more than one bit is ever set.
- FIFO read is synchronous. The word appears on fifo_data slice in cycle N+1. The executor registers the popped index at the end of N and samples that slice during N+1.
- Consume event: valid_out & !downstream_full in a cycle.
- Capture at the end of N+1:
  - Output register empty, or being consumed this cycle: the word goes to data_out, and valid_out=1 in N+2. Minimum grant-to-valid latency is 2 cycles.
  - Otherwise the word goes to the skid, and skid_valid=1.
- A consume event while the skid is full moves skid to data_out and clears the skid in the same cycle.
- Throughput: 1 word/cycle with downstream_full=0 and a continuous grant stream.
- FSM of the output stage:
  - EMPTY: valid_out=0. Goes to FULL on capture.
  - FULL: valid_out=1, skid empty. Stays on consume+capture. Goes to EMPTY on consume without capture. Goes to SKID on capture without consume.
  - SKID: valid_out=1, skid full. Goes to FULL on consume.
- Any arrival in SKID is impossible because accept is blocked while skid_valid=1. The bench asserts this.
- While valid_out=1 and downstream_full=1, data_out holds stable.
- Grant rejection:
  - Trigger: selector_enb & enb with either buf_empty[selector]=1 or selector>=QUEUE_QUANTITY.
  - Response: no pop; grant_err=1 registered in N+1 for exactly one cycle.
- A grant blocked only by downstream_full or skid_valid is neither an error nor remembered. The arbiter is expected to re-grant.
- enb=0: grants are ignored with no grant_err. Output stage and skid continue to drain.
- Simultaneous consume and capture in FULL: data_out loads the new word, valid_out stays 1, no bubble.

Optional Feature:
READ_EXEC_STATS_EN
- Defined:
  - Adds output served_count [QUEUE_QUANTITY*16].
  - Per-queue 16-bit counter, incremented on each pop of that queue. Wraps 0xFFFF->0, no saturation.
  - Cleared by rst.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Reset mid-run:
  - Stimulus: rst low during FULL with skid full.
  - Required response: valid_out=0, pop=0, data_out=0 immediately (asynchronous), and stays so until the first grant after release.
- Single grant:
  - Stimulus: selector=2, selector_enb=1, queue 2 holds 0xA5.
  - Required response: pop=4'b0100 in cycle N; data_out=0xA5 with valid_out=1 in N+2.
- Back-to-back:
  - Stimulus: grants q0,q1,q3,q0 on consecutive cycles with downstream_full=0, words 0x11,0x22,0x33,0x44.
  - Required response: valid_out high 4 consecutive cycles from N+2, data in order.
- Backpressure:
  - Stimulus: downstream_full=1 asserted the cycle after two consecutive grants are accepted.
  - Required response:
    - The second word goes to the skid and further grants are not popped.
    - data_out holds the first word.
    - On release, the words emerge in order with no loss or duplication.
- Empty/out-of-range:
  - Stimulus (a): selector=1 with buf_empty=4'b0010.
  - Stimulus (b): QUEUE_QUANTITY=3, selector=3.
  - Required response: pop=0 and a one-cycle grant_err pulse in N+1 for each case.
- Stats (READ_EXEC_STATS_EN):
  - Stimulus: 65537 pops of queue 0.
  - Required response: served_count[15:0]=1; other queues 0.
